// File: rtl/fifo_pkg.sv
// Shared default constants for the synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_DEF_DATA_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH      = 16;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one synchronous write port and one
// synchronous read port. The read result is held in a register that clears
// on reset; the storage array itself is never cleared.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; holds its value when no read is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and
// full/empty flags decoded from the count register.
// Optional sticky overflow/underflow flags: define FIFO_ERR_FLAGS_EN.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    full,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                    overflow,
    output logic                    underflow
`endif
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come straight from the count register, so they are glitch-free
    // relative to the clock and need no state of their own.
    assign full   = (count == COUNT_MAX);
    assign empty  = (count == '0);
    // A full FIFO refuses the write even if a read frees a slot this cycle;
    // an empty FIFO refuses the read even if a write fills it this cycle.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Pointers wrap naturally at DEPTH (power of two); count tracks net change.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            if (wr_acc && !rd_acc)      count <= count + (ADDR_WIDTH+1)'(1);
            else if (rd_acc && !wr_acc) count <= count - (ADDR_WIDTH+1)'(1);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags: any refused request latches until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end
`endif

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based reference model.
// Honours FIFO_ERR_FLAGS_EN when defined.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          full;
    logic          empty;
    logic [DW-1:0] rd_data;
    logic [4:0]    count;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int total = 0;
    int bad   = 0;

    // reference model
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd = '0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .count    (count)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    // One clock with the given requests; model advances by FIFO rules.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        bit wa, ra;
        wr_en = w; wr_data = d; rd_en = r;
        wa = w && (q.size() < DEPTH);
        ra = r && (q.size() > 0);
        if (w && q.size() == DEPTH) m_ovf = 1'b1;
        if (r && q.size() == 0)     m_udf = 1'b1;
        @(posedge clk);
        if (ra) m_rd = q.pop_front();
        if (wa) q.push_back(d);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_rd = '0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(5);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
`ifdef FIFO_ERR_FLAGS_EN
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_flags got=%0b%0b exp=00", overflow, underflow); end
`endif
    endtask

    task automatic test_single();
        step(1'b1, 8'hAB, 1'b0);
        total++; if (empty !== 1'b0 || count !== 5'd1) begin bad++; $display("FAIL single_write got empty=%0b count=%0d exp empty=0 count=1", empty, count); end
        step(1'b0, 8'h00, 1'b1);
        total++; if (rd_data !== 8'hAB) begin bad++; $display("FAIL single_read got=%h exp=ab", rd_data); end
        total++; if (empty !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL single_drain got empty=%0b count=%0d exp empty=1 count=0", empty, count); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0);
        total++; if (full !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL fill got full=%0b count=%0d exp full=1 count=16", full, count); end
        step(1'b1, 8'hFF, 1'b0);
        total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL overflow_drop got count=%0d exp=16", count); end
`ifdef FIFO_ERR_FLAGS_EN
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_flag got=%0b exp=1", overflow); end
`endif
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            total++; if (rd_data !== DW'(i)) begin bad++; $display("FAIL drain[%0d] got=%h exp=%h", i, rd_data, DW'(i)); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", empty); end
        step(1'b0, '0, 1'b1);
        total++; if (rd_data !== 8'h0F || count !== 5'd0) begin bad++; $display("FAIL underflow_hold got rd=%h count=%0d exp rd=0f count=0", rd_data, count); end
`ifdef FIFO_ERR_FLAGS_EN
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL underflow_flag got=%0b exp=1", underflow); end
`endif
    endtask

    task automatic test_simultaneous();
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b1);
        total++; if (count !== 5'd2 || rd_data !== 8'h11) begin bad++; $display("FAIL simul got count=%0d rd=%h exp count=2 rd=11", count, rd_data); end
        step(1'b0, '0, 1'b1);
        total++; if (rd_data !== 8'h22) begin bad++; $display("FAIL simul_rd2 got=%h exp=22", rd_data); end
        step(1'b0, '0, 1'b1);
        total++; if (rd_data !== 8'h33 || empty !== 1'b1) begin bad++; $display("FAIL simul_rd3 got=%h empty=%0b exp=33 empty=1", rd_data, empty); end
        // wr+rd while empty: only the write happens
        step(1'b1, 8'h44, 1'b1);
        total++; if (count !== 5'd1 || rd_data !== 8'h33) begin bad++; $display("FAIL simul_empty got count=%0d rd=%h exp count=1 rd=33", count, rd_data); end
        // fill, then wr+rd while full: only the read happens
        for (int i = 1; i < DEPTH; i++) step(1'b1, DW'(8'h50 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        total++; if (count !== 5'd15 || rd_data !== 8'h44) begin bad++; $display("FAIL simul_full got count=%0d rd=%h exp count=15 rd=44", count, rd_data); end
        do_reset(1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            step(1'b1, d, 1'b0);
            step(1'b0, '0, 1'b1);
            total++; if (rd_data !== d) begin bad++; $display("FAIL wrap[%0d] got=%h exp=%h", i, rd_data, d); end
        end
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0);
        total++; if (count !== 5'd5) begin bad++; $display("FAIL prereset_count got=%0d exp=5", count); end
        do_reset(1);
        total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL midreset got count=%0d empty=%0b exp count=0 empty=1", count, empty); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic w, r;
            w = ($urandom_range(0, 99) < ((i / 50) % 2 ? 70 : 35));
            r = ($urandom_range(0, 99) < ((i / 50) % 2 ? 35 : 70));
            step(w, DW'($urandom), r);
            total++;
            if (int'(count) !== q.size() || rd_data !== m_rd ||
                full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) begin
                bad++;
                $display("FAIL random[%0d] got count=%0d rd=%h full=%0b empty=%0b exp count=%0d rd=%h",
                         i, count, rd_data, full, empty, q.size(), m_rd);
            end
`ifdef FIFO_ERR_FLAGS_EN
            total++;
            if (overflow !== m_ovf || underflow !== m_udf) begin
                bad++;
                $display("FAIL random_flags[%0d] got=%0b%0b exp=%0b%0b", i, overflow, underflow, m_ovf, m_udf);
            end
`endif
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
